// File: rtl/keyboard_pkg.sv
// keyboard_pkg: scancodes, matrix geometry, receiver states and keymap tables
package keyboard_pkg;
    localparam int ROWS  = 8;
    localparam int COLS  = 5;
    localparam int NKEYS = ROWS * COLS;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_LCTRL  = 8'h14;
    localparam logic [7:0] SC_F11    = 8'h78;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    localparam int KEY_CS = 0 * COLS + 0;
    localparam int KEY_SS = 7 * COLS + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {C_BKSP, C_LEFT, C_DOWN, C_UP, C_RIGHT} comp_t;
    localparam int NCOMP = int'(C_RIGHT) + 1;

    // Index is row*COLS+col; entry is the unextended scancode of that key
    localparam logic [7:0] KEYMAP [NKEYS] = '{
        8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
        8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
        8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
        8'h29, 8'h14, 8'h3A, 8'h31, 8'h32
    };

    // Composite keys press CS plus the digit key listed in COMPKEY
    localparam logic [7:0] COMPMAP [NCOMP] = '{SC_BKSP, SC_LEFT, SC_DOWN, SC_UP, SC_RIGHT};
    localparam logic [NCOMP-1:0] COMPEXT = 5'b11110;
    localparam int COMPKEY [NCOMP] = '{4*COLS+0, 3*COLS+4, 4*COLS+4, 4*COLS+3, 4*COLS+2};

    function automatic logic ignored(input logic [7:0] b);
        return b inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    endfunction
endpackage

// File: rtl/keyboard_matrix_if.sv
// keyboard_matrix_if: PS/2 lines plus the CPU half-row scan and NMI request
interface keyboard_matrix_if;
    logic       ps2Ck;
    logic       ps2Dq;
    logic [7:0] row;
    logic [4:0] col;
    logic       nmi;
    modport master (output ps2Ck, ps2Dq, row, input col, nmi);
    modport slave  (input ps2Ck, ps2Dq, row, output col, nmi);
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: synchronised PS/2 frame receiver with parity check and stall watchdog
module ps2_rx
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT = 65536
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Ck,
    input  logic       ps2Dq,
    output logic [7:0] data,
    output logic       strobe
);
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [1:0] cks, dqs;
    logic ckd, par, fall, dq, tmo, good;
    logic [2:0] cnt;
    logic [WW-1:0] wd;
    rx_state_t state, next;

    assign fall = ckd & ~cks[1];
    assign dq   = dqs[1];
    assign tmo  = wd == WW'(TIMEOUT);
    assign good = state == RX_STOP && fall && dq && (^{data, par}) && !tmo;

    always_comb begin
        next = state;
        if (tmo) next = RX_IDLE;
        else if (fall)
            case (state)
                RX_IDLE:   next = dq ? RX_IDLE : RX_DATA;
                RX_DATA:   next = cnt == 3'd7 ? RX_PARITY : RX_DATA;
                RX_PARITY: next = RX_STOP;
                default:   next = RX_IDLE;
            endcase
    end

    // Clock/data sync flops reset high so the idle bus never looks like an edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cks    <= 2'b11;
            dqs    <= 2'b11;
            ckd    <= 1'b1;
            state  <= RX_IDLE;
            cnt    <= '0;
            wd     <= '0;
            data   <= '0;
            par    <= 1'b0;
            strobe <= 1'b0;
        end else begin
            cks    <= {cks[0], ps2Ck};
            dqs    <= {dqs[0], ps2Dq};
            ckd    <= cks[1];
            state  <= next;
            strobe <= good;
            wd     <= (fall || state == RX_IDLE) ? '0 : wd + 1'b1;
            if (state == RX_IDLE) cnt <= '0;
            if (fall && state == RX_DATA) begin
                data <= {dq, data[7:1]};
                cnt  <= cnt + 3'd1;
            end
            if (fall && state == RX_PARITY) par <= dq;
        end
    end
endmodule

// File: rtl/keyboard_matrix.sv
// keyboard_matrix: set-2 scancode decoder driving the 8x5 half-row key matrix
module keyboard_matrix
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT = 65536
) (
    input logic             clock,
    input logic             reset,
    keyboard_matrix_if.slave bus
);
    logic [7:0] code;
    logic stb, ext, brk, f11, dh, ch, fh;
    logic [5:0] di;
    comp_t ci;
    logic [NKEYS-1:0] dk, m;
    logic [NCOMP-1:0] comp;
    logic [COLS-1:0] any;

    ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .clock  (clock),
        .reset  (reset),
        .ps2Ck  (bus.ps2Ck),
        .ps2Dq  (bus.ps2Dq),
        .data   (code),
        .strobe (stb)
    );

    always_comb begin
        dh = 1'b0;
        di = '0;
        ch = 1'b0;
        ci = C_BKSP;
        fh = !ext && code == SC_F11;
        for (int i = 0; i < NKEYS; i++)
            if (!ext && code == KEYMAP[i]) begin
                dh = 1'b1;
                di = 6'(i);
            end
        if ((!ext && code == SC_RSHIFT) || (ext && code == SC_LCTRL)) begin
            dh = 1'b1;
            di = ext ? 6'(KEY_SS) : 6'(KEY_CS);
        end
        for (int i = 0; i < NCOMP; i++)
            if (ext == COMPEXT[i] && code == COMPMAP[i]) begin
                ch = 1'b1;
                ci = comp_t'(i);
            end
    end

    // Prefix bytes only set flags; any other non-ignored byte consumes them
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext  <= 1'b0;
            brk  <= 1'b0;
            f11  <= 1'b0;
            dk   <= '0;
            comp <= '0;
        end else if (stb) begin
            if (code == SC_EXT) ext <= 1'b1;
            else if (code == SC_BRK) brk <= 1'b1;
            else if (!ignored(code)) begin
                if (dh) dk[di] <= ~brk;
                if (ch) comp[ci] <= ~brk;
                if (fh) f11 <= ~brk;
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    always_comb begin
        m = dk;
        for (int i = 0; i < NCOMP; i++)
            if (comp[i]) begin
                m[KEY_CS]     = 1'b1;
                m[COMPKEY[i]] = 1'b1;
            end
    end

    always_comb begin
        any = '0;
        for (int n = 0; n < ROWS; n++)
            if (!bus.row[n]) any |= m[n*COLS +: COLS];
    end

    assign bus.col = ~any;
    assign bus.nmi = ~f11;
endmodule
